// File: rtl/dma_copy_engine_if.sv
// Bundle of every handshake channel around the copy engine.
//   master : the copy engine (takes requests, issues commands, forwards data)
//   slave  : the environment / DMA channel model
// Channels: req (copy request), read_cmd / write_cmd (burst commands),
// read_data -> write_data (beat stream), back (write completions), done.
interface dma_copy_engine_if #(
  parameter int DATA_WIDTH = 512
);
  logic                    req_valid, req_ready;
  logic [63:0]             req_src_addr, req_dst_addr;
  logic [31:0]             req_length;

  logic                    read_cmd_valid, read_cmd_ready;
  logic [63:0]             read_cmd_address;
  logic [31:0]             read_cmd_length;

  logic                    write_cmd_valid, write_cmd_ready;
  logic [63:0]             write_cmd_address;
  logic [31:0]             write_cmd_length;

  logic                    read_data_valid, read_data_ready;
  logic [DATA_WIDTH-1:0]   read_data_data;
  logic                    read_data_last;

  logic                    write_data_valid, write_data_ready;
  logic [DATA_WIDTH-1:0]   write_data_data;
  logic [DATA_WIDTH/8-1:0] write_data_keep;
  logic                    write_data_last;

  logic                    back_valid, back_ready;

  logic                    done_valid, done_ready, done_error;

  modport master (
    input  req_valid, req_src_addr, req_dst_addr, req_length,
    output req_ready,
    output read_cmd_valid, read_cmd_address, read_cmd_length,
    input  read_cmd_ready,
    output write_cmd_valid, write_cmd_address, write_cmd_length,
    input  write_cmd_ready,
    input  read_data_valid, read_data_data, read_data_last,
    output read_data_ready,
    output write_data_valid, write_data_data, write_data_keep, write_data_last,
    input  write_data_ready,
    input  back_valid,
    output back_ready,
    output done_valid, done_error,
    input  done_ready
  );

  modport slave (
    output req_valid, req_src_addr, req_dst_addr, req_length,
    input  req_ready,
    input  read_cmd_valid, read_cmd_address, read_cmd_length,
    output read_cmd_ready,
    input  write_cmd_valid, write_cmd_address, write_cmd_length,
    output write_cmd_ready,
    output read_data_valid, read_data_data, read_data_last,
    input  read_data_ready,
    input  write_data_valid, write_data_data, write_data_keep, write_data_last,
    output write_data_ready,
    output back_valid,
    input  back_ready,
    input  done_valid, done_error,
    output done_ready
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Command-level copy engine. Takes one (src, dst, length) request, splits it
// into bursts of at most MAX_BURST_BYTES, issues a read then a write command
// per burst, passes read beats straight through to the write stream, then
// waits for one back pulse per burst before reporting done.
// Ports: clock, reset_n (async active-low), bus (dma_copy_engine_if.master).
module dma_copy_engine #(
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BURST_BYTES = 4096
) (
  input  logic               clock,
  input  logic               reset_n,
  dma_copy_engine_if.master  bus
);
  localparam int          BEAT_BYTES = DATA_WIDTH / 8;
  localparam int          LSB        = $clog2(BEAT_BYTES);
  localparam logic [31:0] MAX_B      = 32'(MAX_BURST_BYTES);
  localparam logic [63:0] AMASK      = ~64'(BEAT_BYTES - 1);
  localparam logic [31:0] LMASK      = ~32'(BEAT_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, WR_CMD, DATA, WAIT_BACK, DONE
  } state_t;

  state_t      state_q;
  logic [63:0] src_q, dst_q;
  logic [31:0] rem_q, sent_q, back_cnt_q, beats_q;
  logic        err_q;

  logic [31:0] burst, back_cnt_d, req_len_t;
  logic        rd_fire, back_fire, beat_last;

  // Burst length is a pure function of the remaining count, which only moves
  // on the final beat, so both commands of a burst see the same value.
  assign burst      = (rem_q > MAX_B) ? MAX_B : rem_q;
  assign req_len_t  = bus.req_length & LMASK;
  assign beat_last  = (beats_q == 32'd1);
  assign rd_fire    = bus.read_data_valid & bus.read_data_ready;
  assign back_fire  = bus.back_valid & bus.back_ready;
  // Includes a pulse landing this cycle so WAIT_BACK can exit without delay.
  assign back_cnt_d = back_cnt_q + {31'd0, back_fire};

  assign bus.req_ready         = (state_q == IDLE);
  assign bus.read_cmd_valid    = (state_q == RD_CMD);
  assign bus.read_cmd_address  = src_q;
  assign bus.read_cmd_length   = burst;
  assign bus.write_cmd_valid   = (state_q == WR_CMD);
  assign bus.write_cmd_address = dst_q;
  assign bus.write_cmd_length  = burst;
  assign bus.read_data_ready   = (state_q == DATA) & bus.write_data_ready;
  assign bus.write_data_valid  = (state_q == DATA) & bus.read_data_valid;
  assign bus.write_data_data   = bus.read_data_data;
  assign bus.write_data_keep   = '1;
  assign bus.write_data_last   = (state_q == DATA) & beat_last;
  assign bus.back_ready        = (state_q != IDLE);
  assign bus.done_valid        = (state_q == DONE);
  assign bus.done_error        = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      sent_q     <= '0;
      back_cnt_q <= '0;
      beats_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      back_cnt_q <= back_cnt_d;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          src_q      <= bus.req_src_addr & AMASK;
          dst_q      <= bus.req_dst_addr & AMASK;
          rem_q      <= req_len_t;
          sent_q     <= '0;
          back_cnt_q <= '0;
          state_q    <= (req_len_t == 32'd0) ? DONE : RD_CMD;
        end
        RD_CMD: if (bus.read_cmd_ready) state_q <= WR_CMD;
        WR_CMD: if (bus.write_cmd_ready) begin
          beats_q <= burst >> LSB;
          state_q <= DATA;
        end
        DATA: if (rd_fire) begin
          beats_q <= beats_q - 32'd1;
          // Framing mismatch is only flagged; the data keeps flowing.
          if (bus.read_data_last != beat_last) err_q <= 1'b1;
          if (beat_last) begin
            src_q   <= src_q + 64'(burst);
            dst_q   <= dst_q + 64'(burst);
            rem_q   <= rem_q - burst;
            sent_q  <= sent_q + 32'd1;
            state_q <= (rem_q != burst) ? RD_CMD : WAIT_BACK;
          end
        end
        WAIT_BACK: if (back_cnt_d == sent_q) state_q <= DONE;
        DONE: if (bus.done_ready) begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_copy_engine.sv
// Randomized bench for dma_copy_engine with a queue-based DMA model.
module tb_dma_copy_engine;
  localparam int DW   = 512;
  localparam int MAXB = 4096;
  localparam int BB   = DW / 8;

  typedef struct packed { logic [63:0] a; logic [31:0] l; } cmd_t;
  typedef struct packed { logic [DW-1:0] d; logic last; logic flag; } beat_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dma_copy_engine_if #(.DATA_WIDTH(DW)) bus();
  dma_copy_engine #(.DATA_WIDTH(DW), .MAX_BURST_BYTES(MAXB)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  int n_chk = 0, n_err = 0;
  cmd_t  rdq[$], wrq[$];
  beat_t dma_beats[$], exp_wr[$];
  int back_pend, backs, nb, nbeats, gidx, wstall;

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_src_addr = '0; bus.req_dst_addr = '0; bus.req_length = '0;
    bus.read_cmd_ready = 0; bus.write_cmd_ready = 0;
    bus.read_data_valid = 0; bus.read_data_data = '0; bus.read_data_last = 0;
    bus.write_data_ready = 0; bus.back_valid = 0; bus.done_ready = 0;
  endtask

  task automatic clear_model();
    rdq.delete(); wrq.delete(); dma_beats.delete(); exp_wr.delete();
    back_pend = 0; backs = 0; nb = 0; nbeats = 0; gidx = 0; wstall = 0;
  endtask

  // inj: beat index (within the request) whose last flag the DMA corrupts, -1 none.
  // abort_beats: >0 drops reset after that many written beats.
  task automatic run_req(input logic [63:0] src, input logic [63:0] dst,
                         input logic [31:0] len, input int inj, input bit bp,
                         input int abort_beats);
    logic [31:0] tlen, rem, b;
    logic [63:0] a, d;
    bit exp_err, done_seen, fin, rf, wf;
    int cyc;
    clear_model();
    tlen = len & ~32'(BB - 1);
    a = src & ~64'(BB - 1);
    d = dst & ~64'(BB - 1);
    rem = tlen;
    while (rem != 0) begin
      b = (rem > MAXB) ? MAXB : rem;
      rdq.push_back('{a, b});
      wrq.push_back('{d, b});
      a += 64'(b); d += 64'(b); rem -= b; nb++;
    end
    exp_err = (inj >= 0) && (inj < int'(tlen / BB));

    @(negedge clock);
    chk("req_ready", bus.req_ready, 1);
    chk("idle_back_ready", bus.back_ready, 0);
    bus.req_valid = 1; bus.req_src_addr = src; bus.req_dst_addr = dst; bus.req_length = len;
    done_seen = 0; fin = 0; cyc = 0;
    while (!fin) begin
      @(negedge clock);
      cyc++;
      bus.req_valid = 0;
      bus.read_cmd_ready   = ($urandom % 4) != 0;
      bus.write_cmd_ready  = bp ? (wstall >= 20) : (($urandom % 4) != 0);
      bus.write_data_ready = bp ? (cyc % 2 == 1) : (($urandom % 4) != 0);
      bus.read_data_valid  = (dma_beats.size() > 0) && (($urandom % 4) != 0);
      if (dma_beats.size() > 0) begin
        bus.read_data_data = dma_beats[0].d;
        bus.read_data_last = dma_beats[0].flag;
      end
      bus.back_valid = (back_pend > 0) && ($urandom % 2 == 1);
      bus.done_ready = $urandom % 2 == 1;
      #1;
      if (bus.read_cmd_valid) begin
        if (rdq.size() == 0) chk("rdcmd_extra", 1, 0);
        else begin
          chk("rd_addr", bus.read_cmd_address, rdq[0].a);
          chk("rd_len", bus.read_cmd_length, rdq[0].l);
          if (bus.read_cmd_ready) begin
            for (int i = 0; i < int'(rdq[0].l / BB); i++) begin
              beat_t bt;
              bt.d = rand_beat();
              bt.last = (i == int'(rdq[0].l / BB) - 1);
              bt.flag = bt.last ^ (gidx == inj);
              gidx++;
              dma_beats.push_back(bt);
              exp_wr.push_back(bt);
            end
            void'(rdq.pop_front());
          end
        end
      end
      if (bus.write_cmd_valid) begin
        if (wrq.size() == 0) chk("wrcmd_extra", 1, 0);
        else begin
          chk("wr_addr", bus.write_cmd_address, wrq[0].a);
          chk("wr_len", bus.write_cmd_length, wrq[0].l);
          if (bus.write_cmd_ready) begin void'(wrq.pop_front()); wstall = 0; end
          else wstall++;
        end
      end
      if (bus.read_data_ready) chk("rdr_mirror", bus.write_data_ready, 1);
      rf = bus.read_data_valid & bus.read_data_ready;
      wf = bus.write_data_valid & bus.write_data_ready;
      if (rf || wf) chk("rd_wr_fire", rf, wf);
      if (wf) begin
        if (exp_wr.size() == 0) chk("wbeat_extra", 1, 0);
        else begin
          chk("wdata", bus.write_data_data, exp_wr[0].d);
          chk("wlast", bus.write_data_last, exp_wr[0].last);
          chk("wkeep", bus.write_data_keep, {(DW/8){1'b1}});
          if (exp_wr[0].last) back_pend++;
          void'(exp_wr.pop_front());
        end
        nbeats++;
      end
      if (rf && dma_beats.size() > 0) void'(dma_beats.pop_front());
      if (bus.done_valid && !done_seen) begin
        done_seen = 1;
        chk("done_backs", 32'(backs), 32'(nb));
        chk("done_err", bus.done_error, exp_err);
        chk("work_left", 32'(rdq.size() + wrq.size() + exp_wr.size()), 0);
        if (tlen == 0) chk("zero_latency", cyc <= 2, 1);
      end
      if (bus.back_valid && bus.back_ready) begin back_pend--; backs++; end
      if (bus.done_valid && bus.done_ready) fin = 1;
      if (abort_beats > 0 && nbeats >= abort_beats) begin
        reset_n = 0;
        #1;
        chk("rst_valids_low", {bus.read_cmd_valid, bus.write_cmd_valid, bus.write_data_valid,
                               bus.read_data_ready, bus.done_valid, bus.done_error}, 0);
        idle_inputs();
        clear_model();
        repeat (2) @(negedge clock);
        reset_n = 1;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        fin = 1;
      end
      if (!fin && cyc > 20000) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
    end
  endtask

  initial begin
    idle_inputs();
    clear_model();
    repeat (3) @(negedge clock);
    chk("reset_outs", {bus.read_cmd_valid, bus.write_cmd_valid, bus.write_data_valid,
                       bus.read_data_ready, bus.done_valid, bus.done_error}, 0);
    reset_n = 1;
    #1;
    chk("reset_req_ready", bus.req_ready, 1);

    run_req(64'h0, 64'h10000, 32'd256, -1, 0, 0);            // single burst
    run_req(64'h0, 64'h80000, 32'd10240, -1, 0, 0);          // 4096,4096,2048
    run_req(64'h4000, 64'h9000, 32'd10240, -1, 1, 0);        // backpressure
    run_req(64'h100, 64'h200, 32'd0, -1, 0, 0);              // zero length
    run_req(64'h0, 64'h2000, 32'd256, 1, 0, 0);              // last on beat 2
    run_req(64'h40, 64'h3000, 32'd256, -1, 0, 0);            // error cleared
    run_req(64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F800, 32'd8192, -1, 0, 0); // wrap
    run_req(64'h13F, 64'h27F, 32'd300, -1, 0, 0);            // truncation
    run_req(64'h0, 64'h100000, 32'd12288, -1, 0, 70);        // reset in DATA
    run_req(64'h0, 64'h500, 32'd64, -1, 0, 0);               // fresh request
    for (int k = 0; k < 8; k++) begin
      logic [63:0] s, d;
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
      run_req(s, d, $urandom_range(0, 3 * MAXB / BB) * BB, ($urandom % 3 == 0) ? int'($urandom_range(0, 8)) : -1,
              $urandom % 2 == 1, 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
